// File: rtl/median_filter_stream_if.sv
`default_nettype none
// ============================================================================
//  median_filter_stream_if
//  Control, input-stream and output-stream signals of median_filter_stream.
//  Revision: 1.0
// ============================================================================
interface median_filter_stream_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, in_valid, in_data,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, mode, in_valid, in_data,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/median_filter_stream.sv
`default_nettype none
// ============================================================================
//  median_filter_stream
//  Streaming 3x3 median/min/max filter with two on-chip line buffers.
//  Revision: 1.0
// ============================================================================
module median_filter_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 554,
    parameter int IMG_H  = 430,
    parameter int BORDER = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    median_filter_stream_if.slave   bus
);

    localparam int            CW         = $clog2(IMG_W);
    localparam int            RW         = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] f_med3(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    // ------------------------------------------------------------------ state
    state_t            r_state;
    logic [1:0]        r_mode;
    logic [CW-1:0]     r_icol;
    logic [RW-1:0]     r_irow;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_fhead;
    logic [CW-1:0]     r_fcol;

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_col [3];
    logic              r_col_v;
    logic              r_col_emit;

    logic [DATA_W-1:0] r_win [3][3];
    logic              r_win_v;
    logic [CW-1:0]     r_ocol;
    logic [RW-1:0]     r_orow;

    logic [DATA_W-1:0] r_s1_lo [3];
    logic [DATA_W-1:0] r_s1_md [3];
    logic [DATA_W-1:0] r_s1_hi [3];
    logic [DATA_W-1:0] r_s1_ctr;
    logic              r_s1_bdr;
    logic              r_s1_v;

    logic [DATA_W-1:0] r_s2_maxlo;
    logic [DATA_W-1:0] r_s2_medmd;
    logic [DATA_W-1:0] r_s2_minhi;
    logic [DATA_W-1:0] r_s2_minlo;
    logic [DATA_W-1:0] r_s2_maxhi;
    logic [DATA_W-1:0] r_s2_ctr;
    logic              r_s2_bdr;
    logic              r_s2_v;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;

    logic              w_accept;
    logic              w_emit_in;
    logic              w_drained;
    logic              w_flush_emit;
    logic              w_flush_last;
    logic [DATA_W-1:0] w_flush_data;
    logic              w_win_border;
    logic              w_frame_start;
    logic [DATA_W-1:0] w_rank;
    logic [DATA_W-1:0] w_bdr_val;

    assign w_accept      = bus.in_valid & r_in_ready;
    assign w_frame_start = (r_state == S_IDLE) & bus.start;
    // A window is complete once pixel IMG_W+1 of the frame has arrived.
    assign w_emit_in     = (r_irow > RW'(1)) || ((r_irow == RW'(1)) && (r_icol != '0));
    assign w_drained     = ~(r_col_v | r_win_v | r_s1_v | r_s2_v);
    assign w_flush_emit  = (r_state == S_FLUSH) & w_drained;
    assign w_flush_last  = ~r_fhead & (r_fcol == C_LAST_COL);
    // Final IMG_W+1 centres: (IMG_H-2, IMG_W-1) from the older buffer, then the last row.
    assign w_flush_data  = (BORDER != 0) ? '0 : (r_fhead ? r_lb1[IMG_W-1] : r_lb0[r_fcol]);
    assign w_win_border  = (r_orow == '0) || (r_orow == C_LAST_ROW) ||
                           (r_ocol == '0) || (r_ocol == C_LAST_COL);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'd0;
            r_icol     <= '0;
            r_irow     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fhead    <= 1'b0;
            r_fcol     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_FILL;
                        r_mode     <= bus.mode;
                        r_icol     <= '0;
                        r_irow     <= '0;
                        r_fhead    <= 1'b1;
                        r_fcol     <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        if (r_icol == C_LAST_COL) begin
                            r_icol <= '0;
                            if (r_irow == C_LAST_ROW) begin
                                r_state    <= S_FLUSH;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_irow <= r_irow + RW'(1);
                            end
                        end else begin
                            r_icol <= r_icol + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_drained) begin
                        if (r_fhead) begin
                            r_fhead <= 1'b0;
                        end else if (r_fcol == C_LAST_COL) begin
                            r_state <= S_DONE;
                        end else begin
                            r_fcol <= r_fcol + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------ line buffers and column
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_icol] <= r_lb0[r_icol];
            r_lb0[r_icol] <= bus.in_data;
            r_col[0]      <= r_lb1[r_icol];
            r_col[1]      <= r_lb0[r_icol];
            r_col[2]      <= bus.in_data;
        end
    end

    // Window advances only on a new column, so input gaps stall it cleanly.
    always_ff @(posedge clk) begin
        if (r_col_v) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
                r_win[i][2] <= r_col[i];
            end
        end
    end

    // ------------------------------------------------------- pipeline valids
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_v    <= 1'b0;
            r_col_emit <= 1'b0;
            r_win_v    <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_ocol     <= '0;
            r_orow     <= '0;
        end else begin
            r_col_v    <= w_accept;
            r_col_emit <= w_accept & w_emit_in;
            r_win_v    <= r_col_v & r_col_emit;
            r_s1_v     <= r_win_v;
            r_s2_v     <= r_s1_v;
            if (w_frame_start) begin
                r_ocol <= '0;
                r_orow <= '0;
            end else if (r_win_v) begin
                if (r_ocol == C_LAST_COL) begin
                    r_ocol <= '0;
                    r_orow <= r_orow + RW'(1);
                end else begin
                    r_ocol <= r_ocol + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------- rank stage 1: sort each row
    always_ff @(posedge clk) begin
        if (r_win_v) begin
            for (int i = 0; i < 3; i++) begin
                r_s1_lo[i] <= f_min(f_min(r_win[i][0], r_win[i][1]), r_win[i][2]);
                r_s1_md[i] <= f_med3(r_win[i][0], r_win[i][1], r_win[i][2]);
                r_s1_hi[i] <= f_max(f_max(r_win[i][0], r_win[i][1]), r_win[i][2]);
            end
            r_s1_ctr <= r_win[1][1];
            r_s1_bdr <= w_win_border;
        end
    end

    // ------------------------------- rank stage 2: reduce across sorted rows
    always_ff @(posedge clk) begin
        if (r_s1_v) begin
            r_s2_maxlo <= f_max(f_max(r_s1_lo[0], r_s1_lo[1]), r_s1_lo[2]);
            r_s2_medmd <= f_med3(r_s1_md[0], r_s1_md[1], r_s1_md[2]);
            r_s2_minhi <= f_min(f_min(r_s1_hi[0], r_s1_hi[1]), r_s1_hi[2]);
            r_s2_minlo <= f_min(f_min(r_s1_lo[0], r_s1_lo[1]), r_s1_lo[2]);
            r_s2_maxhi <= f_max(f_max(r_s1_hi[0], r_s1_hi[1]), r_s1_hi[2]);
            r_s2_ctr   <= r_s1_ctr;
            r_s2_bdr   <= r_s1_bdr;
        end
    end

    // Median of nine = med3(max of row minima, median of row medians, min of row maxima).
    always_comb begin
        w_rank = f_med3(r_s2_maxlo, r_s2_medmd, r_s2_minhi);
        case (r_mode)
            2'd1:    w_rank = r_s2_minlo;
            2'd2:    w_rank = r_s2_maxhi;
            default: w_rank = f_med3(r_s2_maxlo, r_s2_medmd, r_s2_minhi);
        endcase
    end

    assign w_bdr_val = (BORDER != 0) ? '0 : r_s2_ctr;

    // ------------------------------------- rank stage 3 / output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_flush_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_flush_data;
            r_out_last  <= w_flush_last;
        end else begin
            r_out_valid <= r_s2_v;
            r_out_last  <= 1'b0;
            if (r_s2_v) begin
                r_out_data <= r_s2_bdr ? w_bdr_val : w_rank;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_stream.sv
`default_nettype none
// ============================================================================
//  tb_median_filter_stream
//  Directed, table-driven bench for a 5x4 frame; BORDER=0 and BORDER=1 in parallel.
//  Revision: 1.0
// ============================================================================
module tb_median_filter_stream;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int NV = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_filter_stream_if #(.DATA_W(DW)) if0 ();
    median_filter_stream_if #(.DATA_W(DW)) if1 ();

    assign if1.start    = if0.start;
    assign if1.mode     = if0.mode;
    assign if1.in_valid = if0.in_valid;
    assign if1.in_data  = if0.in_data;

    median_filter_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    median_filter_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        int             pat;
        logic [1:0]     mode;
        bit             gaps;
        logic [N*8-1:0] e0;
        logic [N*8-1:0] e1;
    } vec_t;

    vec_t tbl [NV];
    int   rnd [N];
    int   acc [N];
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         t0 [$];
    int         l0 [$];
    int         l1 [$];
    int         lq [$];
    int         dq [$];

    always @(negedge clk) begin
        if (if0.out_valid) begin
            q0.push_back(if0.out_data);
            t0.push_back(cyc);
            if (if0.out_last) l0.push_back(q0.size() - 1);
        end
        if (if1.out_valid) begin
            q1.push_back(if1.out_data);
            if (if1.out_last) l1.push_back(q1.size() - 1);
        end
        if (if0.out_last) lq.push_back(cyc);
        if (if0.done)     dq.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit bdr(input int k);
        return (k / W == 0) || (k / W == H - 1) || (k % W == 0) || (k % W == W - 1);
    endfunction

    function automatic int pix(input int pat, input int k);
        case (pat)
            0:       return 'h40;
            1:       return (k == 2 * W + 2) ? 255 : 0;
            2:       return 10 * (k / W) + k % W;
            default: return rnd[k];
        endcase
    endfunction

    function automatic int hand(input int pat, input int md, input int b, input int k);
        int r = k / W;
        int c = k % W;
        case (pat)
            0:       return (b != 0 && bdr(k)) ? 0 : 'h40;
            1:       return (md == 2 && r >= 1 && r <= 2 && c >= 1 && c <= 3) ? 255 : 0;
            default: return (b != 0 && bdr(k)) ? 0 : 10 * r + c;
        endcase
    endfunction

    // Reference for random frames: gather the neighbourhood and insertion-sort it.
    function automatic int model(input int pat, input int md, input int b, input int k);
        int v [9];
        int r = k / W;
        int c = k % W;
        int n = 0;
        int t;
        if (bdr(k)) return (b != 0) ? 0 : pix(pat, k);
        for (int dr = -1; dr <= 1; dr++)
            for (int dcol = -1; dcol <= 1; dcol++) begin
                v[n] = pix(pat, (r + dr) * W + c + dcol);
                n++;
            end
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        if (md == 1) return v[0];
        if (md == 2) return v[8];
        return v[4];
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, ".in_ready0"},  if0.in_ready,  0);
        chk({nm, ".out_valid0"}, if0.out_valid, 0);
        chk({nm, ".out_data0"},  if0.out_data,  0);
        chk({nm, ".out_last0"},  if0.out_last,  0);
        chk({nm, ".busy0"},      if0.busy,      0);
        chk({nm, ".done0"},      if0.done,      0);
        chk({nm, ".in_ready1"},  if1.in_ready,  0);
        chk({nm, ".out_valid1"}, if1.out_valid, 0);
        chk({nm, ".busy1"},      if1.busy,      0);
    endtask

    task automatic drive_frame(input int pat, input logic [1:0] md, input bit gaps,
                               input int npix, input bit spam);
        int k = 0;
        int guard = 0;
        q0.delete(); q1.delete(); t0.delete();
        l0.delete(); l1.delete(); lq.delete(); dq.delete();
        @(negedge clk);
        if0.start = 1'b1;
        if0.mode  = md;
        @(negedge clk);
        if0.start = 1'b0;
        if0.mode  = ~md;
        chk("busy_after_start", if0.busy, 1);
        while (k < npix && guard < 1000) begin
            guard++;
            if (spam && k == 10) begin
                if0.start = 1'b1;
                if0.mode  = 2'd2;
            end else begin
                if0.start = 1'b0;
            end
            if (gaps && $urandom_range(1) == 0) begin
                if0.in_valid = 1'b0;
                if0.in_data  = 8'hEE;
            end else begin
                if0.in_valid = 1'b1;
                if0.in_data  = 8'(pix(pat, k));
                if (if0.in_ready) begin
                    acc[k] = cyc + 1;
                    k++;
                end
            end
            @(negedge clk);
        end
        if0.start    = 1'b0;
        if0.in_valid = 1'b0;
        if (k < npix) chk("accept_timeout", k, npix);
    endtask

    task automatic finish_frame(input string nm, input logic [N*8-1:0] e0,
                                input logic [N*8-1:0] e1, input bit spam);
        int bad = 0;
        if (spam) begin
            chk({nm, ".busy_in_flush"}, if0.busy, 1);
            if0.start = 1'b1;
            if0.mode  = 2'd1;
            @(negedge clk);
            if0.start = 1'b0;
        end
        for (int i = 0; i < 200 && dq.size() == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({nm, ".count0"},  q0.size(), N);
        chk({nm, ".count1"},  q1.size(), N);
        chk({nm, ".ndone"},   dq.size(), 1);
        chk({nm, ".nlast"},   lq.size(), 1);
        if (dq.size() > 0 && lq.size() > 0) chk({nm, ".done_after_last"}, dq[0], lq[0] + 1);
        if (l0.size() > 0) chk({nm, ".last_idx0"}, l0[0], N - 1);
        if (l1.size() > 0) chk({nm, ".last_idx1"}, l1[0], N - 1);
        for (int k = 0; k < N; k++) begin
            if (k < q0.size()) chk($sformatf("%s.b0.k%0d", nm, k), q0[k], e0[k*8 +: 8]);
            if (k < q1.size()) chk($sformatf("%s.b1.k%0d", nm, k), q1[k], e1[k*8 +: 8]);
        end
        for (int k = 0; k < N - W - 1; k++)
            if (k < t0.size() && t0[k] != acc[k + W + 1] + 4) bad++;
        chk({nm, ".latency_bad"}, bad, 0);
        chk({nm, ".busy_end"},     if0.busy,     0);
        chk({nm, ".in_ready_end"}, if0.in_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pats [NV]  = '{0, 1, 1, 2, 3, 3, 3, 3, 3};
        int modes [NV] = '{0, 0, 2, 0, 0, 0, 1, 2, 3};
        int gapv [NV]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};

        if0.start    = 1'b0;
        if0.mode     = 2'd0;
        if0.in_valid = 1'b0;
        if0.in_data  = '0;
        for (int k = 0; k < N; k++) rnd[k] = $urandom_range(255);
        for (int i = 0; i < NV; i++) begin
            tbl[i].pat  = pats[i];
            tbl[i].mode = 2'(modes[i]);
            tbl[i].gaps = (gapv[i] != 0);
            for (int k = 0; k < N; k++) begin
                if (pats[i] < 3) begin
                    tbl[i].e0[k*8 +: 8] = 8'(hand(pats[i], modes[i], 0, k));
                    tbl[i].e1[k*8 +: 8] = 8'(hand(pats[i], modes[i], 1, k));
                end else begin
                    tbl[i].e0[k*8 +: 8] = 8'(model(pats[i], modes[i], 0, k));
                    tbl[i].e1[k*8 +: 8] = 8'(model(pats[i], modes[i], 1, k));
                end
            end
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive_frame(tbl[i].pat, tbl[i].mode, tbl[i].gaps, N, 1'b0);
            finish_frame($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, 1'b0);
        end

        // Abort a frame after 7 accepted pixels, then poke the idle block with data.
        drive_frame(3, 2'd0, 1'b0, 7, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        rst_n = 1'b1;
        if0.in_valid = 1'b1;
        if0.in_data  = 8'hAA;
        repeat (12) @(negedge clk);
        if0.in_valid = 1'b0;
        chk("midreset.no_out0", q0.size(), 0);
        chk("midreset.no_out1", q1.size(), 0);
        chk("midreset.no_done", dq.size(), 0);
        drive_frame(3, 2'd0, 1'b0, N, 1'b0);
        finish_frame("after_reset", tbl[4].e0, tbl[4].e1, 1'b0);

        // start pulses during FILL and FLUSH must not disturb the frame or its mode.
        drive_frame(3, 2'd0, 1'b1, N, 1'b1);
        finish_frame("start_spam", tbl[4].e0, tbl[4].e1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
